ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute stage plus EX/MEM pipeline register for the 5-stage RV32I core. Consumes the registered ID/EX bundle, applies forwarding, runs the ALU, resolves branches and jumps, and drives `PCSrcE`/`PCTargetE` back to fetch. ALU results and control are registered into the memory-stage bundle, with a hold (stall) path for a busy data memory.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE`  in  1 each  registered ID/EX control.
- `ALUSrcAE`  in  1  1 = ALU A operand is `PCE` (AUIPC).
- `JalrE`  in  1  1 = jump target is register-relative.
- `ResultSrcE`  in  2  00 ALU, 01 memory, 10 PC+4.
- `ALUControlE`  in  5  ALU operation.
- `funct3E`  in  3  branch condition / memory size.
- `RD1E, RD2E, PCE, ImmExtE, PCPlus4E`  in  32 each  ID/EX datapath.
- `RdE`  in  5  destination register.
- `ForwardAE, ForwardBE`  in  2 each  00 = RDxE, 01 = `ResultW`, 10 = `ALUResultM`, 11 = RDxE.
- `ResultW`  in  32  writeback value.
- `StallM`  in  1  hold the EX/MEM register.
- `PCSrcE`  out  1  redirect fetch (combinational).
- `PCTargetE`  out  32  redirect address (combinational).
- `RegWriteM, MemWriteM`  out  1 each.
- `ResultSrcM`  out  2.
- `funct3M`  out  3.
- `ALUResultM, WriteDataM, PCPlus4M`  out  32 each.
- `RdM`  out  5.

## Operation
- **Operand selection**
  - `FwdA`/`FwdB` are selected by `ForwardAE`/`ForwardBE`.
  - `SrcA` = `ALUSrcAE ? PCE : FwdA`.
  - `SrcB` = `ALUSrcE ? ImmExtE : FwdB`.
  - `WriteData` = `FwdB`.
- **ALU operations** (`ALUControlE` encoding):
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR.
  - 00101 SLT (signed, result 0/1), 00110 SLTU.
  - 00111 SLL, 01000 SRL, 01001 SRA.
  - 01010 PASSB (LUI).
  - Any other code produces 0.
- **ALU width rules**
  - Shift amount = `SrcB[4:0]`.
  - ADD/SUB wrap modulo 2^32; no overflow flag.
- **Branch condition** is evaluated on `FwdA` vs `FwdB`, never on the immediate:
  - funct3 000 EQ, 001 NE.
  - 100 LT signed, 101 GE signed.
  - 110 LTU, 111 GEU.
  - 010 and 011 evaluate false.
- **Redirect**
  - `PCSrcE` = `JumpE | (BranchE & cond)`.
  - `PCTargetE` = `JalrE ? ((FwdA + ImmExtE) & ~1) : (PCE + ImmExtE)`.
- **EX/MEM register update priority:** `rst` > `StallM` > load.
  - Load: every M output takes its E-stage counterpart (`ALUResultM` = ALU output, `WriteDataM` = `WriteData`).
  - Stall: all M outputs hold their value.
- **No internal flush.** A bubble enters this block as a zeroed ID/EX bundle, which produces `RegWriteM` = `MemWriteM` = 0.

## Timing
- **Reset:** on the first rising edge with `rst` = 1, all M outputs become 0.
  - `PCSrcE` and `PCTargetE` are combinational functions of their inputs; they are not reset.
- **Latency:** one cycle from E inputs to M outputs. `PCSrcE`/`PCTargetE` have zero cycles of latency (same cycle).
- **Forwarding from M:** `ForwardXE` = 10 uses `ALUResultM` as currently registered, including while `StallM` holds it.
- **Stall + redirect:** with `StallM` = 1 and `PCSrcE` = 1 in the same cycle, `PCSrcE` is still driven. Hazard control is responsible for also stalling D/E.
- **`rst` + `StallM`:** `rst` wins and clears the register.
- **Reset mid-operation:** any in-flight M bundle is discarded. Fetch redirects are not gated by `rst`.
- **Unused-field sources:** jumps write `PCPlus4M` via `ResultSrc` 10, so `ALUResultM` content is don't-care but deterministic (the ALU result).

## Test plan
- **Reset:** apply `rst` for 2 cycles with non-zero inputs -> all M outputs = 0; after release, `ADD` of `RD1E`=5, `RD2E`=7 -> `ALUResultM` = 12 one cycle later.
- **ALU sweep:** `RD1E`=0x80000000, `RD2E`=1 ->
  - SUB 0x7FFFFFFF; SLT 1; SLTU 0.
  - SRA 0xC0000000; SRL 0x40000000.
  - Undefined code 01111 -> 0.
- **Forwarding:**
  - `ForwardAE`=10 with `ALUResultM`=0x10, `RD2E`=3, ADD -> 0x13.
  - `ForwardBE`=01 with `ResultW`=4, `RD1E`=1, SUB -> 0xFFFFFFFD.
  - `ForwardBE`=01 with `ALUSrcE`=1 -> `WriteDataM` = 4.
- **Branches** with `PCE`=0x100, `ImmExtE`=0x20:
  - BLT with -1 vs 1 -> `PCSrcE`=1, `PCTargetE`=0x120.
  - BLTU with the same operands -> `PCSrcE`=0.
  - BEQ equal -> 1; funct3 010 -> 0.
- **JALR:** `JalrE`=1, `FwdA`=0x203, `ImmExtE`=2 -> `PCTargetE` = 0x204, `PCSrcE`=1; `PCPlus4M` = `PCPlus4E` next cycle.
- **Stall:**
  - Load ADD result 9, then assert `StallM` for 3 cycles while inputs change -> M outputs stay 9/unchanged.
  - Deassert -> the next edge loads the new values.
  - `rst` during the stall -> all M outputs 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : RV32I execute stage (forwarding, ALU, branch/jump resolution)
//            followed by the EX/MEM pipeline register with a hold path.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic            ALUSrcAE,
    input  logic            JalrE,
    input  logic [1:0]      ResultSrcE,
    input  logic [4:0]      ALUControlE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      funct3M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM
);

    localparam logic [4:0] c_ALU_ADD   = 5'd0;
    localparam logic [4:0] c_ALU_SUB   = 5'd1;
    localparam logic [4:0] c_ALU_AND   = 5'd2;
    localparam logic [4:0] c_ALU_OR    = 5'd3;
    localparam logic [4:0] c_ALU_XOR   = 5'd4;
    localparam logic [4:0] c_ALU_SLT   = 5'd5;
    localparam logic [4:0] c_ALU_SLTU  = 5'd6;
    localparam logic [4:0] c_ALU_SLL   = 5'd7;
    localparam logic [4:0] c_ALU_SRL   = 5'd8;
    localparam logic [4:0] c_ALU_SRA   = 5'd9;
    localparam logic [4:0] c_ALU_PASSB = 5'd10;

    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-2:0] c_ZERO_HI    = '0;

    logic [XLEN-1:0] r_alu_result_m;
    logic [XLEN-1:0] r_write_data_m;
    logic [XLEN-1:0] r_pc_plus4_m;
    logic [4:0]      r_rd_m;
    logic            r_reg_write_m;
    logic            r_mem_write_m;
    logic [1:0]      r_result_src_m;
    logic [2:0]      r_funct3_m;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_src_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_result;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_pc_rel;

    // Forwarding from M reads the registered value, so a held (stalled) result still forwards.
    always_comb begin
        w_fwd_a = RD1E;
        case (ForwardAE)
            2'b01:   w_fwd_a = ResultW;
            2'b10:   w_fwd_a = r_alu_result_m;
            default: w_fwd_a = RD1E;
        endcase
    end

    always_comb begin
        w_fwd_b = RD2E;
        case (ForwardBE)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = r_alu_result_m;
            default: w_fwd_b = RD2E;
        endcase
    end

    assign w_src_a = ALUSrcAE ? PCE : w_fwd_a;
    assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;
    assign w_shamt = w_src_b[4:0];

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            c_ALU_ADD:   w_alu_result = w_src_a + w_src_b;
            c_ALU_SUB:   w_alu_result = w_src_a - w_src_b;
            c_ALU_AND:   w_alu_result = w_src_a & w_src_b;
            c_ALU_OR:    w_alu_result = w_src_a | w_src_b;
            c_ALU_XOR:   w_alu_result = w_src_a ^ w_src_b;
            c_ALU_SLT:   w_alu_result = {c_ZERO_HI, $signed(w_src_a) < $signed(w_src_b)};
            c_ALU_SLTU:  w_alu_result = {c_ZERO_HI, w_src_a < w_src_b};
            c_ALU_SLL:   w_alu_result = w_src_a << w_shamt;
            c_ALU_SRL:   w_alu_result = w_src_a >> w_shamt;
            c_ALU_SRA:   w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
            c_ALU_PASSB: w_alu_result = w_src_b;
            default:     w_alu_result = '0;
        endcase
    end

    // Branch compare uses the forwarded registers, never the immediate operand.
    assign w_eq  = (w_fwd_a == w_fwd_b);
    assign w_lt  = ($signed(w_fwd_a) < $signed(w_fwd_b));
    assign w_ltu = (w_fwd_a < w_fwd_b);

    always_comb begin
        w_cond = 1'b0;
        case (funct3E)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_fwd_a + ImmExtE;
    assign w_pc_rel   = PCE + ImmExtE;
    assign PCSrcE     = JumpE | (BranchE & w_cond);
    assign PCTargetE  = JalrE ? (w_jalr_sum & c_ALIGN_MASK) : w_pc_rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_pc_plus4_m   <= '0;
            r_rd_m         <= '0;
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= '0;
            r_funct3_m     <= '0;
        end else if (!StallM) begin
            r_alu_result_m <= w_alu_result;
            r_write_data_m <= w_fwd_b;
            r_pc_plus4_m   <= PCPlus4E;
            r_rd_m         <= RdE;
            r_reg_write_m  <= RegWriteE;
            r_mem_write_m  <= MemWriteE;
            r_result_src_m <= ResultSrcE;
            r_funct3_m     <= funct3E;
        end
    end

    assign ALUResultM = r_alu_result_m;
    assign WriteDataM = r_write_data_m;
    assign PCPlus4M   = r_pc_plus4_m;
    assign RdM        = r_rd_m;
    assign RegWriteM  = r_reg_write_m;
    assign MemWriteM  = r_mem_write_m;
    assign ResultSrcM = r_result_src_m;
    assign funct3M    = r_funct3_m;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Directed-vector bench for ex_mem_stage with an M-bundle scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, JalrE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        StallM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
    } m_t;

    m_t sb[$];
    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .JalrE(JalrE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E),
        .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .StallM(StallM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .funct3M(funct3M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    function automatic m_t mk(input logic [31:0] alu, input logic [31:0] wd,
                              input logic [31:0] pc4, input logic [4:0] rd,
                              input logic rw, input logic mw,
                              input logic [1:0] rs, input logic [2:0] f3);
        m_t e;
        e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd;
        e.rw = rw; e.mw = mw; e.rs = rs; e.f3 = f3;
        return e;
    endfunction

    // Monitor: the M bundle is presented after every rising edge that has an expectation queued.
    always @(posedge clk) begin
        m_t act;
        m_t exp;
        #1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            act = mk(ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM, funct3M);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL m_bundle t=%0t alu=%h/%h wd=%h/%h pc4=%h/%h rd=%0d/%0d rw=%b/%b mw=%b/%b rs=%b/%b f3=%b/%b (actual/required)",
                         $time, act.alu, exp.alu, act.wd, exp.wd, act.pc4, exp.pc4, act.rd, exp.rd,
                         act.rw, exp.rw, act.mw, exp.mw, act.rs, exp.rs, act.f3, exp.f3);
            end
        end
    end

    task automatic clr();
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0; ALUSrcAE = 0;
        JalrE = 0; ResultSrcE = 0; ALUControlE = 0; funct3E = 0;
        RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0; RdE = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    // Queue the expectation for the coming edge, then advance to the next falling edge.
    task automatic tick(input m_t e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_redirect(input string name, input logic src, input logic [31:0] tgt);
        #1;
        checks++;
        if (PCSrcE !== src || PCTargetE !== tgt) begin
            errors++;
            $display("FAIL %s PCSrcE=%b PCTargetE=%h required PCSrcE=%b PCTargetE=%h",
                     name, PCSrcE, PCTargetE, src, tgt);
        end
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] exp_alu);
        ALUControlE = op;
        tick(mk(exp_alu, RD2E, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000));
    endtask

    initial begin
        m_t zero;
        zero = mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000);
        clr();
        StallM = 0;
        rst = 1;
        RD1E = 5; RD2E = 7; RegWriteE = 1; MemWriteE = 1; RdE = 9;
        PCPlus4E = 32'h8; ResultSrcE = 2'b10; funct3E = 3'b011;
        tick(zero);
        tick(zero);

        rst = 0;
        clr(); RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 3; PCPlus4E = 32'h44;
        tick(mk(32'd12, 32'd7, 32'h44, 5'd3, 1'b1, 1'b0, 2'b00, 3'b000));

        // ALU sweep on 0x80000000 / 1
        clr(); RD1E = 32'h8000_0000; RD2E = 32'h1;
        alu_op(5'b00001, 32'h7FFF_FFFF);
        alu_op(5'b00101, 32'h1);
        alu_op(5'b00110, 32'h0);
        alu_op(5'b01001, 32'hC000_0000);
        alu_op(5'b01000, 32'h4000_0000);
        alu_op(5'b00111, 32'h0);
        alu_op(5'b00100, 32'h8000_0001);
        alu_op(5'b01111, 32'h0);
        ALUSrcE = 1; ImmExtE = 32'h1234_5000;
        alu_op(5'b01010, 32'h1234_5000);
        ALUSrcAE = 1; PCE = 32'h100; ImmExtE = 32'h1000;
        alu_op(5'b00000, 32'h1100);

        // Forwarding
        clr(); RD1E = 32'h10;
        tick(mk(32'h10, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000));
        clr(); ForwardAE = 2'b10; RD1E = 32'hDEAD; RD2E = 32'h3;
        tick(mk(32'h13, 32'h3, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000));
        clr(); ForwardBE = 2'b01; ResultW = 32'h4; RD1E = 32'h1; RD2E = 32'd99; ALUControlE = 5'b00001;
        tick(mk(32'hFFFF_FFFD, 32'h4, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000));
        clr(); ForwardBE = 2'b01; ResultW = 32'h4; RD1E = 32'h1; ALUSrcE = 1; ImmExtE = 32'h50; MemWriteE = 1;
        tick(mk(32'h51, 32'h4, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00, 3'b000));

        // Branches with PCE=0x100, ImmExtE=0x20
        clr(); BranchE = 1; PCE = 32'h100; ImmExtE = 32'h20; RD1E = 32'hFFFF_FFFF; RD2E = 32'h1;
        funct3E = 3'b100; chk_redirect("blt", 1'b1, 32'h120);
        tick(mk(32'h0, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b100));
        funct3E = 3'b110; chk_redirect("bltu", 1'b0, 32'h120);
        tick(mk(32'h0, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b110));
        funct3E = 3'b101; chk_redirect("bge", 1'b0, 32'h120);
        funct3E = 3'b001; chk_redirect("bne", 1'b1, 32'h120);
        RD1E = 32'h5; RD2E = 32'h5;
        funct3E = 3'b000; chk_redirect("beq", 1'b1, 32'h120);
        tick(mk(32'hA, 32'h5, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000));
        funct3E = 3'b010; chk_redirect("f3_010", 1'b0, 32'h120);
        tick(mk(32'hA, 32'h5, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b010));
        funct3E = 3'b000; BranchE = 0; chk_redirect("nobranch", 1'b0, 32'h120);

        // Jumps
        clr(); JalrE = 1; JumpE = 1; RD1E = 32'h203; ImmExtE = 32'h2; ALUSrcE = 1;
        PCPlus4E = 32'h58; RegWriteE = 1; ResultSrcE = 2'b10; RdE = 5'd1;
        chk_redirect("jalr", 1'b1, 32'h204);
        tick(mk(32'h205, 32'h0, 32'h58, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000));
        clr(); JumpE = 1; PCE = 32'h100; ImmExtE = 32'h40;
        chk_redirect("jal", 1'b1, 32'h140);

        // Stall holds the bundle; forwarding from M sees the held value
        clr(); RD1E = 32'h4; RD2E = 32'h5; RegWriteE = 1; RdE = 5'd7;
        tick(mk(32'h9, 32'h5, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 3'b000));
        StallM = 1;
        for (int i = 0; i < 3; i++) begin
            clr(); RD1E = 32'd100 + i; RD2E = 32'd3; MemWriteE = 1; RdE = 5'd20; PCPlus4E = 32'hAA;
            tick(mk(32'h9, 32'h5, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 3'b000));
        end
        clr(); JumpE = 1; PCE = 32'h200; ImmExtE = 32'h4;
        chk_redirect("stall_redirect", 1'b1, 32'h204);
        clr(); StallM = 0; ForwardAE = 2'b10; RD2E = 32'h1; RdE = 5'd2; PCPlus4E = 32'h64;
        tick(mk(32'hA, 32'h1, 32'h64, 5'd2, 1'b0, 1'b0, 2'b00, 3'b000));
        StallM = 1; rst = 1; RegWriteE = 1;
        tick(zero);
        rst = 0; StallM = 0; clr();
        tick(zero);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
